// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: raw immediate in, extended constant out.
// The design attaches through the slave modport; the producer/consumer side uses master.
interface imm_extend_pipe_if #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        ctrl;
  logic [IMM_W-1:0]  imm;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_illegal;
  logic              pfx_pending;

  modport slave (
    input  in_valid, ctrl, imm, out_ready,
    output in_ready, out_valid, out_data, out_illegal, pfx_pending
  );

  modport master (
    output in_valid, ctrl, imm, out_ready,
    input  in_ready, out_valid, out_data, out_illegal, pfx_pending
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered, handshaked immediate extender (decode -> execute), one output stage.
// Optional prefix mode (ctrl 101 glues two immediates) is built when IMM_EXT_PREFIX_EN is defined.
module imm_extend_pipe #(
  parameter int DATA_W    = 16,
  parameter int IMM_W     = 12,
  parameter int PFX_SHIFT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  imm_extend_pipe_if.slave bus
);

  function automatic logic [DATA_W-1:0] sext_low(input logic [IMM_W-1:0] v);
    logic signed [IMM_W-2:0]  s;
    logic signed [DATA_W-1:0] r;
    s = v[IMM_W-2:0];
    r = s;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sext_full(input logic [IMM_W-1:0] v);
    logic signed [IMM_W-1:0]  s;
    logic signed [DATA_W-1:0] r;
    s = v;
    r = s;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sext_byte(input logic [IMM_W-1:0] v);
    logic signed [7:0]        s;
    logic signed [DATA_W-1:0] r;
    s = v[7:0];
    r = s;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] zext_full(input logic [IMM_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    r[IMM_W-1:0] = v;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] byte_high(input logic [IMM_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    r[DATA_W-1 -: 8] = v[7:0];
    return r;
  endfunction

  // Prefix bits shifted past DATA_W are dropped; the low part is always zero-extended.
  function automatic logic [DATA_W-1:0] merge_pfx(input logic [IMM_W-1:0] p,
                                                  input logic [IMM_W-1:0] v);
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    hi = '0;
    hi[IMM_W-1:0] = p;
    hi = hi << PFX_SHIFT;
    lo = '0;
    lo[PFX_SHIFT-1:0] = v[PFX_SHIFT-1:0];
    return hi | lo;
  endfunction

  // Returns {illegal, data}; 101 lands in default and is illegal unless the prefix path claims it.
  function automatic logic [DATA_W:0] extend(input logic [2:0] c, input logic [IMM_W-1:0] v);
    case (c)
      3'b000:  return {1'b0, sext_low(v)};
      3'b001:  return {1'b0, zext_full(v)};
      3'b010:  return {1'b0, byte_high(v)};
      3'b011:  return {1'b0, sext_byte(v)};
      3'b100:  return {1'b0, sext_full(v)};
      default: return {1'b1, {DATA_W{1'b0}}};
    endcase
  endfunction

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              ill_p1;

  logic              accept;
  logic              load_pfx;
  logic              beat_ill;
  logic [DATA_W-1:0] beat_data;

`ifdef IMM_EXT_PREFIX_EN
  typedef enum logic {IDLE, HELD} pfx_state_e;
  pfx_state_e        state;
  logic [IMM_W-1:0]  pfx_p1;
`endif

  assign bus.in_ready = !flush && (!vld_p1 || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // ---- p0: decode ctrl and form the candidate beat ----
  always_comb begin
    {beat_ill, beat_data} = extend(bus.ctrl, bus.imm);
    load_pfx = 1'b0;
`ifdef IMM_EXT_PREFIX_EN
    if (bus.ctrl == 3'b101) begin
      load_pfx = 1'b1;
    end else if (state == HELD && !beat_ill) begin
      beat_data = merge_pfx(pfx_p1, bus.imm);
    end
`endif
  end

  // ---- p1: output register and prefix FSM ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ill_p1  <= 1'b0;
`ifdef IMM_EXT_PREFIX_EN
      state   <= IDLE;
      pfx_p1  <= '0;
`endif
    end else if (flush) begin
      vld_p1  <= 1'b0;
`ifdef IMM_EXT_PREFIX_EN
      state   <= IDLE;
`endif
    end else begin
      if (accept && !load_pfx) begin
        vld_p1  <= 1'b1;
        data_p1 <= beat_data;
        ill_p1  <= beat_ill;
      end else if (bus.out_ready) begin
        vld_p1  <= 1'b0;
      end
`ifdef IMM_EXT_PREFIX_EN
      if (accept) begin
        if (load_pfx) begin
          pfx_p1 <= bus.imm;
          state  <= HELD;
        end else begin
          state  <= IDLE;
        end
      end
`endif
    end
  end

  assign bus.out_valid   = vld_p1;
  assign bus.out_data    = data_p1;
  assign bus.out_illegal = ill_p1;
`ifdef IMM_EXT_PREFIX_EN
  assign bus.pfx_pending = (state == HELD);
`else
  assign bus.pfx_pending = 1'b0;
`endif

endmodule
